// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM states, nibble width and operand-width check for the serial arithmetic blocks
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int NIB_W = 4;
  function automatic bit width_ok(input int w);
    return (w % NIB_W == 0) && (w >= 2 * NIB_W);
  endfunction
endpackage

// File: rtl/nibble_serial_subtractor_cla.sv
// CLA: 4-bit carry look-ahead adder slice
module CLA (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  // generate/propagate terms expanded so every carry is two levels deep
  always_comb begin
    g = A & B;
    p = A ^ B;
    c[0] = Cin;
    c[1] = g[0] | (p[0] & Cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & Cin);
    Sum  = p ^ c[3:0];
    Cout = c[4];
  end
endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: WIDTH-bit a - b computed one nibble per clock through a single CLA slice
module nibble_serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);
  localparam int NNIB = WIDTH / NIB_W;
  localparam int IW = $clog2(NNIB);
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and at least 8");
  end
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic borrow_q, borrow_d, ovf_q, ovf_d;
  logic [NIB_W-1:0] sum;
  logic cout, last;
  assign last = idx_q == IW'(NNIB - 1);
  CLA u_cla (
    .A(a_q[idx_q*NIB_W +: NIB_W]),
    .B(b_q[idx_q*NIB_W +: NIB_W]),
    .Cin(carry_q),
    .Sum(sum),
    .Cout(cout)
  );
  // b is stored inverted so the slice computes a + ~b + 1; flags are taken on the last nibble
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    carry_d = carry_q;
    a_d = a_q;
    b_d = b_q;
    diff_d = diff_q;
    borrow_d = borrow_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        a_d = a;
        b_d = ~b;
        carry_d = 1'b1;
        idx_d = '0;
        diff_d = '0;
      end
      RUN: begin
        diff_d[idx_q*NIB_W +: NIB_W] = sum;
        carry_d = cout;
        if (last) begin
          state_d = DONE;
          borrow_d = ~cout;
          ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[NIB_W-1] != a_q[WIDTH-1]);
        end else idx_d = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      carry_q <= 1'b1;
      a_q <= '0;
      b_q <= '0;
      diff_q <= '0;
      borrow_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      a_q <= a_d;
      b_q <= b_d;
      diff_q <= diff_d;
      borrow_q <= borrow_d;
      ovf_q <= ovf_d;
    end
  end
  assign ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign diff = diff_q;
  assign borrow = borrow_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: scoreboard bench for the 16-bit serial subtractor
module tb_nibble_serial_subtractor;
  logic clk = 0, rst_n = 0, start = 0;
  logic [15:0] a = 0, b = 0;
  logic ready, busy, done, borrow, ovf;
  logic [15:0] diff;
  int checks = 0, errors = 0, cyc = 0, n_acc = 0, n_done = 0;
  logic [17:0] exp_q[$];
  int acc_q[$];

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // monitor: every done pulse pops one expected result
  always @(negedge clk) if (rst_n && done) begin
    n_done++;
    if (exp_q.size() == 0) chk("spurious_done", 1, 0);
    else begin
      logic [17:0] e;
      int k;
      e = exp_q.pop_front();
      k = acc_q.pop_front();
      chk("diff", diff, e[17:2]);
      chk("borrow", borrow, e[1]);
      chk("ovf", ovf, e[0]);
      chk("latency", cyc - k, 4);
      chk("busy_in_done", {ready, busy}, 2'b01);
    end
  end

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic [15:0] ed,
                       input logic eb, input logic eo, input bit push);
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    start = 1;
    a = ta;
    b = tb;
    @(posedge clk);
    #1;
    n_acc += push ? 1 : 0;
    if (push) begin
      exp_q.push_back({ed, eb, eo});
      acc_q.push_back(cyc);
    end
    start = 0;
    a = 16'($urandom);
    b = 16'($urandom);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready_busy_done", {ready, busy, done}, 3'b100);
    chk("rst_diff", diff, 16'h0000);
    chk("rst_flags", {borrow, ovf}, 2'b00);
    rst_n = 1;
    @(negedge clk);
    issue(16'h1234, 16'h0034, 16'h1200, 0, 0, 1);
    issue(16'h0000, 16'h0001, 16'hFFFF, 1, 0, 1);
    issue(16'hBEEF, 16'hBEEF, 16'h0000, 0, 0, 1);
    issue(16'h5A5A, 16'h0000, 16'h5A5A, 0, 0, 1);
    issue(16'h0000, 16'h8000, 16'h8000, 1, 1, 1);
    issue(16'h8000, 16'h0001, 16'h7FFF, 0, 1, 1);
    issue(16'h7FFF, 16'hFFFF, 16'h8000, 1, 1, 1);
    wait_idle();
    @(negedge clk);
    chk("hold_after_done", {diff, borrow, ovf}, {16'h8000, 2'b11});
    issue(16'h1111, 16'h0101, 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrun_rst_state", {ready, busy, done}, 3'b100);
    chk("midrun_rst_diff", diff, 16'h0000);
    chk("midrun_rst_flags", {borrow, ovf}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    chk("no_done_after_rst", n_done, n_acc);
    issue(16'h1234, 16'h0034, 16'h1200, 0, 0, 1);
    start = 1;
    a = 16'hFFFF;
    b = 16'h0001;
    repeat (2) @(negedge clk);
    start = 0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("busy_start_ignored", {ready, busy}, 2'b10);
    chk("busy_start_diff", diff, 16'h1200);
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra, rb, rd;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 50 == 0) rb = ra;
      rd = ra - rb;
      issue(ra, rb, rd, ra < rb, (ra[15] != rb[15]) && (rd[15] != ra[15]), 1);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("done_count", n_done, n_acc);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
